// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle shared by the core-side initiator
// and the memory-side responder.
interface data_mem_responder_if;
   logic        request;
   logic        we_re;
   logic [3:0]  mask;
   logic [31:0] address;
   logic [31:0] data_in;
   logic        valid;
   logic [31:0] data_out;
   logic        error;
   logic        busy;

   modport master (
      output request, we_re, mask, address, data_in,
      input  valid, data_out, error, busy
   );

   modport slave (
      input  request, we_re, mask, address, data_in,
      output valid, data_out, error, busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one request at a time, waits WAIT_CYCLES
// extra cycles, then performs a byte-masked write or a full-word read on an
// internal word array and returns a single-cycle valid strobe.
module data_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input logic                  clk,
   input logic                  rst,
   data_mem_responder_if.slave  bus
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [7:0]  WAIT_LD = 8'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic              accept;
   logic              access;

   logic              cmd_we;
   logic [3:0]        cmd_mask;
   logic [29:0]       cmd_word;
   logic signed [31:0] cmd_data;

   logic              valid_q;
   logic              error_q;
   logic [31:0]       data_out_q;

   logic [31:0]       mem [DEPTH];

   logic [AW-1:0]     idx;
   logic              in_range;
   logic              unused_addr_lsb;

   // Byte-lane merge: lanes with a set mask bit take the new data.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lane_en);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (lane_en[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

   // The low two address bits select a byte within the word and play no part here.
   assign unused_addr_lsb = ^bus.address[1:0];

   assign idx      = cmd_word[AW-1:0];
   assign in_range = ((cmd_word >> AW) == '0);

   // Next-state, counter and strobe decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      access    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.request) begin
               accept    = 1'b1;
               cnt_nxt   = WAIT_LD;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else begin
               access    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Control state and response registers; reset returns everything to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
         data_out_q <= 32'd0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         valid_q <= access;
         if (access) begin
            error_q <= !in_range;
            if (in_range && !cmd_we) data_out_q <= mem[idx];
            else                     data_out_q <= 32'd0;
         end else if (state == RESP) begin
            error_q <= 1'b0;
         end
      end
   end

   // Command register: captured only on the accept edge, so later changes on
   // the request lines are ignored until the block is idle again.
   always_ff @(posedge clk) begin
      if (accept) begin
         cmd_we   <= bus.we_re;
         cmd_mask <= bus.mask;
         cmd_word <= bus.address[31:2];
         cmd_data <= bus.data_in;
      end
   end

   // Array write on the access edge; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (access && cmd_we && in_range) begin
         mem[idx] <= merge_lanes(mem[idx], cmd_data, cmd_mask);
      end
   end

   assign bus.valid    = valid_q;
   assign bus.error    = error_q;
   assign bus.data_out = data_out_q;
   assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with no wait states and
// one with three, sharing the command lines but with separate request lines.
module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic        req;
   logic        sel;
   logic        we;
   logic [3:0]  msk;
   logic [31:0] addr;
   logic [31:0] din;

   int n_chk;
   int n_fail;

   data_mem_responder_if i0 ();
   data_mem_responder_if i3 ();

   assign i0.request = req & ~sel;
   assign i0.we_re   = we;
   assign i0.mask    = msk;
   assign i0.address = addr;
   assign i0.data_in = din;

   assign i3.request = req & sel;
   assign i3.we_re   = we;
   assign i3.mask    = msk;
   assign i3.address = addr;
   assign i3.data_in = din;

   logic        vld_s, err_s, busy_s;
   logic [31:0] dout_s;
   assign vld_s  = sel ? i3.valid    : i0.valid;
   assign err_s  = sel ? i3.error    : i0.error;
   assign busy_s = sel ? i3.busy     : i0.busy;
   assign dout_s = sel ? i3.data_out : i0.data_out;

   data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
   data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Full transaction on the selected instance; lat counts ticks from raising
   // request to seeing valid, and one_pulse reports valid and busy low the
   // cycle after.
   task automatic txn(input logic w, input logic [3:0] m, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er,
                      output int lat, output logic one_pulse);
      we = w; msk = m; addr = a; din = d; req = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!vld_s && lat < 40);
      rd = dout_s;
      er = err_s;
      req = 1'b0;
      tick();
      one_pulse = !vld_s && !busy_s;
   endtask

   typedef struct packed {
      logic        we;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        op;

      tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
      tbl[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      tbl[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0,         1'b0};
      tbl[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0,         1'b0};
      tbl[4]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0};
      tbl[5]  = '{1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0,         1'b0};
      tbl[6]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0};
      tbl[7]  = '{1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
      tbl[8]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0102_0304, 32'h0,         1'b0};
      tbl[9]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, 32'h0,         1'b1};
      tbl[10] = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h0102_0304, 1'b0};
      tbl[11] = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
      tbl[12] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0,         1'b0};
      tbl[13] = '{1'b1, 4'h2, 32'h0000_0FFC, 32'h0000_1100, 32'h0,         1'b0};
      tbl[14] = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0,         32'hA5A5_11A5, 1'b0};
      tbl[15] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};

      n_chk = 0; n_fail = 0;
      rst = 1'b0; sel = 1'b0; req = 1'b1;
      we = 1'b1; msk = 4'hF; addr = 32'h40; din = 32'h55;

      // Held in reset with request high: nothing moves.
      repeat (3) tick();
      chk("rst_valid", {31'd0, i0.valid}, 32'd0);
      chk("rst_busy",  {31'd0, i0.busy},  32'd0);
      chk("rst_dout",  i0.data_out,       32'd0);
      chk("rst_error", {31'd0, i0.error}, 32'd0);
      chk("rst_busy3", {31'd0, i3.busy},  32'd0);

      // Release with request held: accept on the first edge.
      rst = 1'b1;
      tick();
      chk("rel_busy",  {31'd0, busy_s}, 32'd1);
      chk("rel_valid", {31'd0, vld_s},  32'd0);
      tick();
      chk("rel_valid2", {31'd0, vld_s}, 32'd1);
      chk("rel_err",    {31'd0, err_s}, 32'd0);
      req = 1'b0;
      tick();
      chk("rel_valid3", {31'd0, vld_s},  32'd0);
      chk("rel_busy3",  {31'd0, busy_s}, 32'd0);

      // Table on the zero-wait instance.
      for (int i = 0; i < NV; i++) begin
         txn(tbl[i].we, tbl[i].mask, tbl[i].addr, tbl[i].data, rd, er, lat, op);
         chk($sformatf("row%0d data", i),  rd,            tbl[i].exp_d);
         chk($sformatf("row%0d error", i), {31'd0, er},   {31'd0, tbl[i].exp_e});
         chk($sformatf("row%0d lat", i),   lat,           32'd2);
         chk($sformatf("row%0d pulse", i), {31'd0, op},   32'd1);
      end

      // Three wait states; command lines scrambled during WAIT.
      sel = 1'b1;
      we = 1'b1; msk = 4'hF; addr = 32'h30; din = 32'h1234_5678; req = 1'b1;
      tick();
      chk("w3_busy_e0", {31'd0, busy_s}, 32'd1);
      chk("w3_vld_e0",  {31'd0, vld_s},  32'd0);
      we = 1'b0; msk = 4'h0; addr = 32'h1000; din = 32'hFFFF_FFFF;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("w3_vld_e%0d", k),  {31'd0, vld_s},  32'd0);
         chk($sformatf("w3_busy_e%0d", k), {31'd0, busy_s}, 32'd1);
      end
      tick();
      chk("w3_vld_e4", {31'd0, vld_s}, 32'd1);
      chk("w3_err_e4", {31'd0, err_s}, 32'd0);
      chk("w3_busy_e4", {31'd0, busy_s}, 32'd1);
      req = 1'b0;
      tick();
      chk("w3_vld_e5",  {31'd0, vld_s},  32'd0);
      chk("w3_busy_e5", {31'd0, busy_s}, 32'd0);
      txn(1'b0, 4'hF, 32'h30, 32'h0, rd, er, lat, op);
      chk("w3_rd_data", rd, 32'h1234_5678);
      chk("w3_rd_lat",  lat, 32'd5);
      chk("w3_rd_pulse", {31'd0, op}, 32'd1);

      // Reset in the middle of a write.
      txn(1'b1, 4'hF, 32'h50, 32'h0BAD_F00D, rd, er, lat, op);
      txn(1'b0, 4'hF, 32'h30, 32'h0, rd, er, lat, op);
      chk("mr_pre_dout", rd, 32'h1234_5678);
      we = 1'b1; msk = 4'hF; addr = 32'h50; din = 32'h9999_9999; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("mr_busy", {31'd0, busy_s}, 32'd0);
      chk("mr_dout", dout_s, 32'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("mr_vld%0d", k), {31'd0, vld_s}, 32'd0);
      end
      rst = 1'b1;
      tick();
      chk("mr_idle", {31'd0, busy_s}, 32'd0);
      txn(1'b0, 4'hF, 32'h50, 32'h0, rd, er, lat, op);
      chk("mr_word", rd, 32'h0BAD_F00D);
      chk("mr_lat",  lat, 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
